// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Constants and types shared by the EX-stage multiplier.
//                WIDTH - operand width (product is 2*WIDTH)
//                CNT_W - iteration counter width (2**CNT_W > WIDTH)
//                mult_state_t - multiplier FSM state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/rca_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder / rca_adder
//  Description : One-bit full adder cell and a parameterised ripple-carry
//                adder built as a chain of those cells.
//  Ports (rca_adder):
//                i_a, i_b  [WIDTH]  addends
//                i_cin     [1]      carry in
//                o_sum     [WIDTH]  sum
//                o_cout    [1]      carry out of the top bit
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule : full_adder

module rca_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .i_a    (i_a[i]),
            .i_b    (i_b[i]),
            .i_cin  (w_carry[i]),
            .o_sum  (o_sum[i]),
            .o_cout (w_carry[i+1])
        );
    end

    assign o_cout = w_carry[WIDTH];
endmodule : rca_adder
`default_nettype wire

// File: rtl/mult_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_unit
//  Description : Sequential shift-add multiplier for MIPS MULT/MULTU.
//                Multiplies magnitudes one multiplier bit per cycle, then
//                fixes the sign in a single extra cycle.
//  Ports       : clk, rst (sync, active high)
//                start, is_signed, op_a, op_b  - request and operands
//                busy (CALC/FIX), done (1-cycle pulse), hi, lo (product)
//  Option      : `define MULT_EARLY_TERM_EN to leave CALC as soon as the
//                remaining multiplier bits are all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_unit #(
    parameter int WIDTH = mips_pkg::WIDTH,
    parameter int CNT_W = mips_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mips_pkg::*;

    mult_state_t        r_state;
    mult_state_t        w_next_state;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_add_sum;
    logic               w_add_cout;
    logic [WIDTH-1:0]   w_mplier_nxt;
    logic               w_last_iter;
    logic [2*WIDTH-1:0] w_aligned;
    logic [2*WIDTH-1:0] w_neg_sum;
    logic               w_neg_cout;
    logic [2*WIDTH-1:0] w_product;

    assign w_accept = start && (r_state == IDLE || r_state == DONE);

    // Magnitudes; -0x80000000 wraps to 0x80000000, which is the correct
    // unsigned magnitude.
    assign w_abs_a = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign w_abs_b = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    // Iteration add: {carry, acc_hi} = acc_hi + (mplier[0] ? mcand : 0)
    assign w_addend = r_mplier[0] ? r_mcand : '0;

    rca_adder #(.WIDTH(WIDTH)) u_iter_add (
        .i_a    (r_acc[2*WIDTH-1:WIDTH]),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    assign w_mplier_nxt = {1'b0, r_mplier[WIDTH-1:1]};

`ifdef MULT_EARLY_TERM_EN
    // After N iterations the accumulator holds product << (WIDTH - N);
    // the counter equals N once CALC has finished.
    logic [CNT_W-1:0] w_shamt;

    assign w_last_iter = (w_mplier_nxt == '0);
    assign w_shamt     = CNT_W'(WIDTH) - r_cnt;
    assign w_aligned   = r_acc >> w_shamt;
`else
    assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_aligned   = r_acc;
`endif

    // Two's complement negation ~p + 1 on a dedicated full-width adder.
    rca_adder #(.WIDTH(2*WIDTH)) u_neg_add (
        .i_a    (~w_aligned),
        .i_b    ('0),
        .i_cin  (1'b1),
        .o_sum  (w_neg_sum),
        .o_cout (w_neg_cout)
    );

    // ~p + 1 only carries out when p is zero, whose negation is zero
    // itself, so the unnegated value is selected in that case.
    assign w_product = (r_neg && !w_neg_cout) ? w_neg_sum : w_aligned;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (w_last_iter) w_next_state = FIX;
            end
            FIX: begin
                busy         = 1'b1;
                w_next_state = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = start ? CALC : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    // {carry, acc_hi, acc_lo} shifted right by one
                    r_acc    <= {w_add_cout, w_add_sum, r_acc[WIDTH-1:1]};
                    r_mplier <= w_mplier_nxt;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    r_hi <= w_product[2*WIDTH-1:WIDTH];
                    r_lo <= w_product[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule : mult_unit
`default_nettype wire

// File: tb/tb_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_unit
//  Description : Self-checking bench for mult_unit: directed MULT/MULTU
//                cases, handshake corner cases, reset abort and randomized
//                operands against a 64-bit arithmetic reference.
//                Honours MULT_EARLY_TERM_EN for latency expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    mult_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: exact 64-bit product
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit sg);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Expected number of CALC iterations
    function automatic int exp_iters(input logic [31:0] b, input bit sg);
        int n;
`ifdef MULT_EARLY_TERM_EN
        logic [31:0] m;
        m = (sg && b[31]) ? (~b + 32'd1) : b;
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`else
        n = 32 + 0 * int'(sg) + 0 * int'(b[0]);
`endif
        return n;
    endfunction

    // Drive one start cycle; returns in cycle 1 of the operation, with the
    // operand inputs scrambled since they only matter in the start cycle.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit sg);
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        is_signed = sg;
        @(posedge clk); #1;
        start     = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    // Wait for done; lat is the cycle number (start cycle = 0) of done.
    task automatic wait_done(output int lat, output logic [31:0] rh, output logic [31:0] rl);
        bit seen;
        seen = 0;
        lat  = 1;
        rh   = '0;
        rl   = '0;
        if (done) seen = 1;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (done) seen = 1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", lat);
            lat = -1;
        end else begin
            rh = hi;
            rl = lo;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sg,
                          output int lat, output logic [31:0] rh, output logic [31:0] rl);
        start_op(a, b, sg);
        wait_done(lat, rh, rl);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_tests++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] ta [7];
        logic [31:0] tb [7];
        bit          ts [7];
        logic [31:0] th [7];
        logic [31:0] tl [7];
        int          lat;
        logic [31:0] rh, rl;
        ta = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'h12345678};
        tb = '{32'd6, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF0, 32'd0};
        ts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        th = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 32'h40000000, 32'h0, 32'h0};
        tl = '{32'h2A, 32'hFFFFFFF1, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], ts[i], lat, rh, rl);
            n_tests++;
            if (rh !== th[i] || rl !== tl[i]) begin
                n_fail++;
                $display("FAIL directed_%0d_product: got %h_%h want %h_%h", i, rh, rl, th[i], tl[i]);
            end
            n_tests++;
            if (lat !== exp_iters(tb[i], ts[i]) + 2) begin
                n_fail++;
                $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, exp_iters(tb[i], ts[i]) + 2);
            end
            @(posedge clk); #1;
            n_tests++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_%0d_done_width: got done=%b one cycle later, want 0", i, done);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int          lat;
        logic [31:0] rh, rl;
        bit          extra;
        start_op(32'd2, 32'd3, 1'b0);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: got %b want 1", busy); end
        start     = 1'b1;
        op_a      = 32'd1;
        op_b      = 32'd1;
        is_signed = 1'b1;
        wait_done(lat, rh, rl);
        n_tests++;
        if (rh !== 32'd0 || rl !== 32'd6) begin
            n_fail++;
            $display("FAIL ignore_product: got %h_%h want 00000000_00000006", rh, rl);
        end
        n_tests++;
        if (lat !== exp_iters(32'd3, 1'b0) + 2) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d want %0d", lat, exp_iters(32'd3, 1'b0) + 2);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) extra = 1;
        end
        n_tests++;
        if (extra) begin n_fail++; $display("FAIL ignore_no_second_op: got activity want idle"); end
    endtask

    task automatic test_back_to_back;
        int          lat;
        logic [31:0] rh, rl;
        run_op(32'd2, 32'd3, 1'b0, lat, rh, rl);
        n_tests++;
        if (rl !== 32'd6) begin n_fail++; $display("FAIL b2b_first: got lo=%h want 6", rl); end
        // still in the DONE cycle: start again immediately
        run_op(32'd4, 32'd5, 1'b0, lat, rh, rl);
        n_tests++;
        if (rh !== 32'd0 || rl !== 32'd20) begin
            n_fail++;
            $display("FAIL b2b_second: got %h_%h want 00000000_00000014", rh, rl);
        end
        n_tests++;
        if (lat !== exp_iters(32'd5, 1'b0) + 2) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d want %0d", lat, exp_iters(32'd5, 1'b0) + 2);
        end
    endtask

    task automatic test_reset_abort;
        int          lat, cyc;
        logic [31:0] rh, rl;
        bit          extra;
        cyc = (exp_iters(32'd9, 1'b0) + 2 > 10) ? 10 : 2;
        start_op(32'd9, 32'd9, 1'b0);
        repeat (cyc - 1) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_hilo: got %h_%h want 0", hi, lo);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra = 1;
        end
        n_tests++;
        if (extra) begin n_fail++; $display("FAIL abort_no_done: got done pulse want none"); end
        run_op(32'd9, 32'd9, 1'b0, lat, rh, rl);
        n_tests++;
        if (rh !== 32'd0 || rl !== 32'h51) begin
            n_fail++;
            $display("FAIL abort_rerun: got %h_%h want 00000000_00000051", rh, rl);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic [31:0] corners [5];
        logic [63:0] exp;
        bit          sg;
        int          lat;
        logic [31:0] rh, rl;
        corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        for (int i = 0; i < 1000; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(0, 255));
                2: begin a = corners[$urandom_range(0, 4)]; b = corners[$urandom_range(0, 4)]; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            exp = ref_prod(a, b, sg);
            run_op(a, b, sg, lat, rh, rl);
            n_tests++;
            if ({rh, rl} !== exp) begin
                n_fail++;
                $display("FAIL random_%0d_product: a=%h b=%h s=%0d got %h_%h want %h", i, a, b, sg, rh, rl, exp);
            end
            n_tests++;
            if (lat !== exp_iters(b, sg) + 2) begin
                n_fail++;
                $display("FAIL random_%0d_latency: got %0d want %0d", i, lat, exp_iters(b, sg) + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mult_unit
`default_nettype wire

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Sequential 32x32 shift-add multiplier that executes MIPS MULT/MULTU and produces the 64-bit {HI, LO} product.
- Sits in the EX stage beside the ALU and consumes the ripple-carry adder built from full_adder cells: one 33-bit add per iteration.
- Uses a start/busy/done handshake toward the pipeline stall logic.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a multiply; accepted only in IDLE or DONE
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU
- op_a  in  WIDTH  multiplicand (rs)
- op_b  in  WIDTH  multiplier (rt)
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse; hi/lo are valid in the same cycle
- hi  out  WIDTH  product[63:32], held until the next accepted start
- lo  out  WIDTH  product[31:0], held until the next accepted start

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- States are IDLE, CALC, FIX and DONE.
- IDLE/DONE with start=1:
  - Latch mcand=|op_a| and mplier=|op_b| (absolute values only when is_signed=1).
  - Latch neg = is_signed & (op_a[31]^op_b[31]).
  - Clear the product register and counter, then go to CALC.
- CALC, once per cycle:
  - If mplier[0]=1, then {carry, acc_hi} = acc_hi + mcand (33-bit, via adder sub-module).
  - Shift {carry, acc_hi, acc_lo} right by 1.
  - Shift mplier right by 1 and increment the counter.
  - After N iterations go to FIX. N = WIDTH unless the optional feature is enabled.
- FIX: if neg=1, the product becomes its 64-bit two's complement negation (~p + 1). Then go to DONE.
- DONE:
  - done=1 for exactly one cycle and hi/lo are updated.
  - Next state is IDLE, or CALC if start=1 in this cycle (back-to-back operation).
- Latency: start is sampled in cycle 0, CALC runs in cycles 1..N, FIX in N+1, and done is high in cycle N+2. Without the optional feature, done is high in cycle 34.
- start while busy=1 is ignored with no side effects. Operands need only be stable in the start cycle.
- |0x80000000| is treated as unsigned 0x80000000. No overflow exists; all 64 product bits are exact.
- rst asserted mid-operation aborts it:
  - Return to IDLE with outputs at reset values.
  - done does not fire for the aborted operation.
- Zero operands still take the full N iterations and yield 0. Negation of 0 stays 0.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined:
  - CALC exits once the remaining mplier becomes 0, with N = max(1, index of the highest set bit of |op_b| + 1).
  - In FIX, the product is first shifted right by (WIDTH - N), then conditionally negated.
  - Results are identical to the undefined case; only latency changes.
- Undefined: N = WIDTH always, with fixed 34-cycle latency and no shifter logic.

Decomposition:
- Shared package mips_pkg:
  - WIDTH and CNT_W constants.
  - State encoding typedef mult_state_t (IDLE=0, CALC=1, FIX=2, DONE=3).
- Sub-module rca_adder: a parameterised ripple-carry adder instantiating full_adder cells, with a carry-out port. It is used for the iteration add.
- Negation uses the same rca_adder instance (operand mux), or a second instance.

Test Plan:
- MULTU 7 x 6 -> hi=0x00000000, lo=0x0000002A. done in cycle 34, or cycle 5 with MULT_EARLY_TERM_EN.
- MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT -1 x -1 -> hi=0, lo=1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- Handshake:
  - Pulse start again while busy with 1 x 1. Required: ignored, and the first result (2 x 3 -> lo=6) completes.
  - start asserted in the DONE cycle. Required: the second result follows N+2 cycles later.
- Reset abort: assert rst in cycle 10 of 9 x 9. Required: next cycle busy=0, hi=lo=0, and no done pulse. A new 9 x 9 then yields lo=0x51.
- Randomized 1000 signed/unsigned pairs checked against a reference 64-bit product, with and without MULT_EARLY_TERM_EN.
